// File: rtl/alu_regfile_unit.sv
// Register file + 8-op ALU behind a cmd/rsp handshake; accept at N, operands at N+1, result/writeback/rsp_valid at N+2.
// The response holds stable under rsp_ready=0, and no command is accepted until the response handshake completes.
module alu_regfile_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_rs1,
  input  logic [ADDR_WIDTH-1:0] cmd_rs2,
  input  logic [ADDR_WIDTH-1:0] cmd_rd,
  input  logic                  cmd_imm_en,
  input  logic [DATA_WIDTH-1:0] cmd_imm,
  input  logic                  cmd_wen,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic [2:0]            rsp_flag,
  input  logic                  hw_wen,
  input  logic [ADDR_WIDTH-1:0] hw_waddr,
  input  logic [DATA_WIDTH-1:0] hw_wdata,
  input  logic [ADDR_WIDTH-1:0] dbg_raddr,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic [31:0]           retired_cnt
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int MSB   = DATA_WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_RESP} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic                  imm_en_q, wen_q;
  logic [DATA_WIDTH-1:0] imm_q, a_q, b_q, res_q;
  logic [2:0]            flag_q;
  logic                  cmd_ready_q, rsp_valid_q;
  logic [31:0]           cnt_q;

  logic [DATA_WIDTH:0]   sum_d, diff_d;
  logic [DATA_WIDTH-1:0] alu_d;
  logic                  carry_d, ovf_d, zero_d;

  always_comb begin
    sum_d   = {1'b0, a_q} + {1'b0, b_q};
    diff_d  = {1'b0, a_q} - {1'b0, b_q};
    alu_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (op_q)
      3'b000: alu_d = a_q & b_q;
      3'b001: alu_d = a_q | b_q;
      3'b010: begin
        alu_d   = sum_d[MSB:0];
        carry_d = sum_d[DATA_WIDTH];
        ovf_d   = (a_q[MSB] == b_q[MSB]) && (sum_d[MSB] != a_q[MSB]);
      end
      3'b011: alu_d = a_q ^ b_q;
      3'b100: alu_d = ~(a_q | b_q);
      // The borrow out of the widened subtract is exactly the unsigned a < b
      3'b101: alu_d = {{(DATA_WIDTH-1){1'b0}}, diff_d[DATA_WIDTH]};
      3'b110: begin
        alu_d   = diff_d[MSB:0];
        carry_d = diff_d[DATA_WIDTH];
        ovf_d   = (a_q[MSB] != b_q[MSB]) && (diff_d[MSB] != a_q[MSB]);
      end
      3'b111: alu_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: alu_d = '0;
    endcase
    zero_d = (alu_d == '0);
  end

  // Entry 0 is never written, so it reads as zero from reset onward
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      if (hw_wen && hw_waddr != '0) regs_q[hw_waddr] <= hw_wdata;
      if (state_q == S_EXEC && wen_q && rd_q != '0) regs_q[rd_q] <= alu_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      imm_en_q    <= 1'b0;
      wen_q       <= 1'b0;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      flag_q      <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          op_q        <= cmd_op;
          rs1_q       <= cmd_rs1;
          rs2_q       <= cmd_rs2;
          rd_q        <= cmd_rd;
          imm_en_q    <= cmd_imm_en;
          imm_q       <= cmd_imm;
          wen_q       <= cmd_wen;
          cmd_ready_q <= 1'b0;
          state_q     <= S_READ;
        end
        S_READ: begin
          a_q     <= regs_q[rs1_q];
          b_q     <= imm_en_q ? imm_q : regs_q[rs2_q];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          res_q       <= alu_d;
          flag_q      <= {ovf_d, carry_d, zero_d};
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          cnt_q       <= cnt_q + 32'd1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = res_q;
  assign rsp_flag    = flag_q;
  assign retired_cnt = cnt_q;
  assign dbg_rdata   = regs_q[dbg_raddr];

endmodule
